// File: rtl/conv_check_stream.sv
// conv_check_stream: k-means convergence checker, Manhattan distance vs threshold per centroid, one verdict per round.
// Optional CONV_MAX_DIST_EN: track and report the largest distance of each completed round.
module conv_check_stream #(
  parameter int NUM_CENT = 8,
  parameter int DIMS = 7,
  parameter int COORD_W = 13,
  parameter int SIGNED_C = 1,
  parameter int ITER_W = 10,
  localparam int CIDX_W = ($clog2(NUM_CENT) > 1) ? $clog2(NUM_CENT) : 1,
  localparam int DATA_W = DIMS * COORD_W,
  localparam int DIST_W = COORD_W + $clog2(DIMS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CIDX_W-1:0] cent_idx,
  input  logic [DATA_W-1:0] old_centroid,
  input  logic [DATA_W-1:0] new_centroid,
  input  logic [DIST_W-1:0] thresh,
  output logic              res_valid,
  output logic              has_converged,
  output logic [ITER_W-1:0] round_cnt,
  output logic              protocol_err,
  output logic [DIST_W-1:0] max_dist
);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_CENT-1:0] mask_q, mask_n, hit;
  logic [COORD_W:0] diff [DIMS];
  logic [COORD_W:0] mag_d [DIMS];
  logic [COORD_W:0] mag_q [DIMS];
  logic [DIST_W-1:0] th_q, sum_d;
  logic acc, first, in_range, bad, full;
  logic s1_v_q, s2_v_q, fail_q, any_fail_q, res_valid_q, conv_q, err_q;
  logic [ITER_W-1:0] cnt_q;

  function automatic logic [COORD_W:0] ext(input logic [COORD_W-1:0] v);
    return {(SIGNED_C != 0) & v[COORD_W-1], v};
  endfunction

  assign in_ready = (state_q == IDLE) || (state_q == COLLECT);
  assign acc = in_valid & in_ready & ~clear;
  assign first = acc & (state_q == IDLE);
  assign res_valid = res_valid_q;
  assign has_converged = conv_q;
  assign round_cnt = cnt_q;
  assign protocol_err = err_q;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CENT; i++) hit[i] = cent_idx == CIDX_W'(i);
    in_range = |hit;
    bad = ~in_range | (|(hit & mask_q));
    mask_n = mask_q | (acc ? hit : '0);
    full = &mask_n;
    state_d = (state_q == DONE) ? IDLE
            : (state_q == DRAIN) ? ((s2_v_q & ~s1_v_q) ? DONE : DRAIN)
            : acc ? (full ? DRAIN : COLLECT) : state_q;
    sum_d = '0;
    for (int d = 0; d < DIMS; d++) begin
      diff[d] = ext(old_centroid[d*COORD_W +: COORD_W]) - ext(new_centroid[d*COORD_W +: COORD_W]);
      mag_d[d] = diff[d][COORD_W] ? -diff[d] : diff[d];
      sum_d = sum_d + DIST_W'(mag_q[d]);
    end
  end

  // Out-of-range beats still load stage 1 but never raise its valid.
  always_ff @(posedge clk)
    if (acc) begin
      mag_q <= mag_d;
      th_q <= thresh;
    end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q <= '0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      fail_q <= 1'b0;
      any_fail_q <= 1'b0;
      res_valid_q <= 1'b0;
      conv_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      mask_q <= '0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      any_fail_q <= 1'b0;
      res_valid_q <= 1'b0;
      conv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= full ? '0 : mask_n;
      s1_v_q <= acc & in_range;
      s2_v_q <= s1_v_q;
      fail_q <= sum_d > th_q;
      res_valid_q <= state_q == DONE;
      any_fail_q <= (first ? 1'b0 : any_fail_q) | (s2_v_q & fail_q);
      err_q <= (first ? 1'b0 : err_q) | (acc & bad);
      if (first) conv_q <= 1'b0;
      else if (state_q == DONE) conv_q <= ~any_fail_q;
      if (state_q == DONE && !(&cnt_q)) cnt_q <= cnt_q + ITER_W'(1);
    end
  end

`ifdef CONV_MAX_DIST_EN
  logic [DIST_W-1:0] sum_q, run_q, max_q;
  assign max_dist = max_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      run_q <= '0;
      max_q <= '0;
    end else begin
      if (s1_v_q) sum_q <= sum_d;
      if (clear || first) run_q <= '0;
      else if (s2_v_q && sum_q > run_q) run_q <= sum_q;
      if (!clear && state_q == DONE) max_q <= run_q;
    end
  end
`else
  assign max_dist = '0;
`endif
endmodule

// File: tb/tb_conv_check_stream.sv
// tb_conv_check_stream: scoreboard bench for conv_check_stream, a K=8 signed instance and a K=5 unsigned instance.
module tb_conv_check_stream;
  typedef struct {logic conv; int rcnt; logic perr; int maxd; int cyc;} exp_t;

  logic clk = 0, rst = 1;
  logic clear0 = 0, in_valid0 = 0, clear5 = 0, in_valid5 = 0;
  logic in_ready0, res_valid0, conv0, perr0, in_ready5, res_valid5, conv5, perr5;
  logic [2:0] cent_idx0 = 0, cent_idx5 = 0;
  logic [90:0] old0 = 0, new0 = 0;
  logic [23:0] old5 = 0, new5 = 0;
  logic [16:0] thresh0 = 0, maxd0;
  logic [10:0] thresh5 = 0, maxd5;
  logic [9:0] rcnt0;
  logic [1:0] rcnt5;
  int checks = 0, errors = 0, cyc = 0, last0 = 0, last5 = 0;
  exp_t q0[$], q5[$];
  exp_t e0, e5;
  int ord4[9] = '{0, 1, 2, 3, 3, 4, 5, 6, 7};
  int ord5[6] = '{0, 1, 6, 2, 3, 4};

  conv_check_stream u_dut0 (
    .clk(clk), .rst(rst), .clear(clear0), .in_valid(in_valid0), .in_ready(in_ready0),
    .cent_idx(cent_idx0), .old_centroid(old0), .new_centroid(new0), .thresh(thresh0),
    .res_valid(res_valid0), .has_converged(conv0), .round_cnt(rcnt0), .protocol_err(perr0), .max_dist(maxd0)
  );

  conv_check_stream #(.NUM_CENT(5), .DIMS(3), .COORD_W(8), .SIGNED_C(0), .ITER_W(2)) u_dut5 (
    .clk(clk), .rst(rst), .clear(clear5), .in_valid(in_valid5), .in_ready(in_ready5),
    .cent_idx(cent_idx5), .old_centroid(old5), .new_centroid(new5), .thresh(thresh5),
    .res_valid(res_valid5), .has_converged(conv5), .round_cnt(rcnt5), .protocol_err(perr5), .max_dist(maxd5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [90:0] pt0(input int c0, input int cr);
    logic [90:0] v;
    for (int d = 0; d < 7; d++) v[d*13 +: 13] = 13'(d == 0 ? c0 : cr);
    return v;
  endfunction

  function automatic logic [23:0] pt5(input int c0, input int cr);
    logic [23:0] v;
    for (int d = 0; d < 3; d++) v[d*8 +: 8] = 8'(d == 0 ? c0 : cr);
    return v;
  endfunction

  task automatic send0(input int idx, input logic [90:0] o, input logic [90:0] n, input int th);
    int k = 0;
    while (!in_ready0 && k < 20) begin @(posedge clk); #1; k++; end
    chk("u0 in_ready before beat", in_ready0, 1);
    in_valid0 = 1; cent_idx0 = 3'(idx); old0 = o; new0 = n; thresh0 = 17'(th);
    @(posedge clk); #1;
    last0 = cyc;
  endtask

  task automatic send5(input int idx, input logic [23:0] o, input logic [23:0] n, input int th);
    int k = 0;
    while (!in_ready5 && k < 20) begin @(posedge clk); #1; k++; end
    chk("u5 in_ready before beat", in_ready5, 1);
    in_valid5 = 1; cent_idx5 = 3'(idx); old5 = o; new5 = n; thresh5 = 11'(th);
    @(posedge clk); #1;
    last5 = cyc;
  endtask

  task automatic exp0(input logic c, input int r, input logic p, input int m);
    q0.push_back('{c, r, p, m, last0 + 3});
  endtask

  task automatic exp5(input logic c, input int r, input logic p, input int m);
    q5.push_back('{c, r, p, m, last5 + 3});
  endtask

  always @(negedge clk)
    if (res_valid0) begin
      if (q0.size() == 0) chk("u0 unexpected res_valid", res_valid0, 0);
      else begin
        e0 = q0.pop_front();
        chk("u0 has_converged", conv0, e0.conv);
        chk("u0 round_cnt", rcnt0, e0.rcnt);
        chk("u0 protocol_err", perr0, e0.perr);
        chk("u0 verdict cycle", cyc, e0.cyc);
`ifdef CONV_MAX_DIST_EN
        chk("u0 max_dist", maxd0, e0.maxd);
`else
        chk("u0 max_dist tied", maxd0, 0);
`endif
      end
    end

  always @(negedge clk)
    if (res_valid5) begin
      if (q5.size() == 0) chk("u5 unexpected res_valid", res_valid5, 0);
      else begin
        e5 = q5.pop_front();
        chk("u5 has_converged", conv5, e5.conv);
        chk("u5 round_cnt", rcnt5, e5.rcnt);
        chk("u5 protocol_err", perr5, e5.perr);
        chk("u5 verdict cycle", cyc, e5.cyc);
`ifdef CONV_MAX_DIST_EN
        chk("u5 max_dist", maxd5, e5.maxd);
`else
        chk("u5 max_dist tied", maxd5, 0);
`endif
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("u0 reset in_ready", in_ready0, 1);
    chk("u0 reset res_valid", res_valid0, 0);
    chk("u0 reset has_converged", conv0, 0);
    chk("u0 reset round_cnt", rcnt0, 0);
    chk("u0 reset protocol_err", perr0, 0);
    chk("u0 reset max_dist", maxd0, 0);
    chk("u5 reset in_ready", in_ready5, 1);
    chk("u5 reset round_cnt", rcnt5, 0);
    // distances 0..7 under threshold 10
    for (int c = 0; c < 8; c++) send0(c, pt0(c, 0), pt0(0, 0), 10);
    exp0(1, 1, 0, 7);
    chk("u0 in_ready low in drain", in_ready0, 0);
    in_valid0 = 0;
    repeat (4) @(posedge clk); #1;
    chk("u0 verdict held", conv0, 1);
    chk("u0 res_valid single cycle", res_valid0, 0);
    // idx7 at distance 11 breaks the threshold
    for (int c = 0; c < 8; c++) send0(c, pt0(c == 7 ? 11 : c, 0), pt0(0, 0), 10);
    exp0(0, 2, 0, 11);
    in_valid0 = 0;
    // distance equal to threshold counts as within
    for (int c = 0; c < 8; c++) send0(c, pt0(10, 0), pt0(0, 0), 10);
    exp0(1, 3, 0, 10);
    in_valid0 = 0;
    // extreme signed span: 7 * 8191 = 57337
    for (int c = 0; c < 8; c++) send0(c, pt0(-4096, -4096), pt0(4095, 4095), 131071);
    exp0(1, 4, 0, 57337);
    in_valid0 = 0;
    for (int c = 0; c < 8; c++) send0(c, pt0(-4096, -4096), pt0(4095, 4095), c == 0 ? 57336 : 57337);
    exp0(0, 5, 0, 57337);
    in_valid0 = 0;
    // duplicate idx 3 carries a failing distance of 20
    for (int i = 0; i < 9; i++) begin
      send0(ord4[i], pt0(i == 4 ? 20 : ord4[i], 0), pt0(0, 0), 10);
      if (i == 4) chk("u0 protocol_err on duplicate", perr0, 1);
    end
    exp0(0, 6, 1, 20);
    in_valid0 = 0;
    for (int c = 0; c < 8; c++) begin
      send0(c, pt0(c, 0), pt0(0, 0), 10);
      if (c == 0) chk("u0 protocol_err cleared by new round", perr0, 0);
    end
    exp0(1, 7, 0, 7);
    in_valid0 = 0;
    // abort after five failing beats; clear beats a same-cycle beat
    for (int c = 0; c < 5; c++) send0(c, pt0(100, 0), pt0(0, 0), 10);
    in_valid0 = 1; cent_idx0 = 5; clear0 = 1;
    @(posedge clk); #1;
    clear0 = 0; in_valid0 = 0;
    chk("u0 in_ready after clear", in_ready0, 1);
    chk("u0 protocol_err after clear", perr0, 0);
    chk("u0 has_converged after clear", conv0, 0);
    repeat (6) @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      send0(c, pt0(c, 0), pt0(0, 0), 10);
      in_valid0 = 0;
      repeat (c % 3) @(posedge clk);
      #1;
    end
    exp0(1, 8, 0, 7);
    // unsigned K=5 instance
    for (int c = 0; c < 5; c++) send5(c, pt5(255, 255), pt5(0, 0), 765);
    exp5(1, 1, 0, 765);
    in_valid5 = 0;
    for (int i = 0; i < 6; i++) begin
      send5(ord5[i], ord5[i] == 6 ? pt5(255, 255) : pt5(1, 1), pt5(0, 0), ord5[i] == 6 ? 0 : 765);
      if (i == 2) chk("u5 protocol_err on out-of-range", perr5, 1);
    end
    exp5(1, 2, 1, 3);
    in_valid5 = 0;
    for (int c = 0; c < 5; c++) send5(c, pt5(255, 255), pt5(0, 0), c == 2 ? 764 : 765);
    exp5(0, 3, 0, 765);
    in_valid5 = 0;
    for (int c = 0; c < 5; c++) send5(c, pt5(1, 1), pt5(0, 0), 765);
    exp5(1, 3, 0, 3);
    in_valid5 = 0;
    k = 0;
    while ((q0.size() != 0 || q5.size() != 0) && k < 20) begin @(posedge clk); #1; k++; end
    // reset while the last beat is still in the pipeline
    for (int c = 0; c < 5; c++) send5(c, pt5(9, 9), pt5(0, 0), 765);
    in_valid5 = 0;
    @(posedge clk); #1;
    chk("u5 in_ready low in drain", in_ready5, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("u5 rst in_ready", in_ready5, 1);
    chk("u5 rst res_valid", res_valid5, 0);
    chk("u5 rst has_converged", conv5, 0);
    chk("u5 rst round_cnt", rcnt5, 0);
    chk("u5 rst protocol_err", perr5, 0);
    chk("u5 rst max_dist", maxd5, 0);
    chk("u0 rst round_cnt", rcnt0, 0);
    repeat (8) @(posedge clk); #1;
    chk("u0 pending verdicts", q0.size(), 0);
    chk("u5 pending verdicts", q5.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
